ex_mem_skid_stage: RTL and testbench

Parametrised EX/MEM pipeline stage register with a valid/ready handshake and a two-entry skid buffer. It sits between the execute stage (ALU, branch-target adder) and the memory stage. It adds three behaviours a plain latch does not have:
- back-pressure (stall) without a combinational ready path;
- synchronous flush that turns in-flight entries into bubbles;
- optional registered branch-taken resolution.

---
 rtl/ex_mem_skid_stage_if.sv | 47 ++++
 rtl/ex_mem_skid_stage.sv | 160 ++++++++++++++++
 tb/tb_ex_mem_skid_stage.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_skid_stage_if.sv
// EX/MEM stage bundle: execute-side entry, memory-side registered entry and fill level.
// The master drives incoming entries and out_ready, and the slave is the pipeline stage.
interface ex_mem_skid_stage_if #(
  parameter int DATA_W = 64,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [RD_W-1:0]   in_rd;
  logic [DATA_W-1:0] in_alu;
  logic [DATA_W-1:0] in_store;
  logic [DATA_W-1:0] in_target;
  logic [CTRL_W-1:0] in_ctrl;
  logic              in_zero;
  logic              in_great;
  logic              in_branch_eq;
  logic              in_branch_gt;

  logic              out_valid;
  logic              out_ready;
  logic [RD_W-1:0]   out_rd;
  logic [DATA_W-1:0] out_alu;
  logic [DATA_W-1:0] out_store;
  logic [DATA_W-1:0] out_target;
  logic [CTRL_W-1:0] out_ctrl;
  logic              out_zero;
  logic              out_great;
  logic              out_branch_eq;
  logic              out_branch_gt;
  logic              out_taken;
  logic [1:0]        occupancy;

  modport master (
    output in_valid, in_rd, in_alu, in_store, in_target, in_ctrl,
           in_zero, in_great, in_branch_eq, in_branch_gt, out_ready,
    input  in_ready, out_valid, out_rd, out_alu, out_store, out_target, out_ctrl,
           out_zero, out_great, out_branch_eq, out_branch_gt, out_taken, occupancy
  );

  modport slave (
    input  in_valid, in_rd, in_alu, in_store, in_target, in_ctrl,
           in_zero, in_great, in_branch_eq, in_branch_gt, out_ready,
    output in_ready, out_valid, out_rd, out_alu, out_store, out_target, out_ctrl,
           out_zero, out_great, out_branch_eq, out_branch_gt, out_taken, occupancy
  );
endinterface

// File: rtl/ex_mem_skid_stage.sv
// EX/MEM pipeline register with a two-entry skid buffer, sync flush and bubble-safe control.
// Define EX_MEM_BRANCH_RESOLVE_EN to build the registered branch-taken decision on out_taken.
module ex_mem_skid_stage #(
  parameter int DATA_W = 64,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 4
) (
  input logic clk,
  input logic reset,
  input logic flush,
  ex_mem_skid_stage_if.slave bus
);

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] store;
    logic [DATA_W-1:0] target;
    logic [CTRL_W-1:0] ctrl;
    logic              zero;
    logic              great;
    logic              branchEq;
    logic              branchGt;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state;
  state_t nextState;
  entry_t mainReg;
  entry_t skidReg;
  entry_t inEntry;
  logic   mainValid;
  logic   skidValid;
  logic   inFire;
  logic   outFire;
  logic   loadMainFromIn;
  logic   loadMainFromSkid;
  logic   loadSkid;
  logic   clearMain;

  assign inEntry = {bus.in_rd, bus.in_alu, bus.in_store, bus.in_target, bus.in_ctrl,
                    bus.in_zero, bus.in_great, bus.in_branch_eq, bus.in_branch_gt};

  // Valid bits come straight from the state register, so in_ready has no path from out_ready.
  assign mainValid    = (state != EMPTY);
  assign skidValid    = (state == TWO);
  assign bus.in_ready = !skidValid;
  assign inFire       = bus.in_valid & bus.in_ready;
  assign outFire      = mainValid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState        = state;
    loadMainFromIn   = 1'b0;
    loadMainFromSkid = 1'b0;
    loadSkid         = 1'b0;
    clearMain        = 1'b0;
    case (state)
      EMPTY: begin
        if (inFire) begin
          loadMainFromIn = 1'b1;
          nextState      = ONE;
        end
      end
      ONE: begin
        if (outFire) begin
          if (inFire) begin
            loadMainFromIn = 1'b1;
          end else begin
            clearMain = 1'b1;
            nextState = EMPTY;
          end
        end else if (inFire) begin
          loadSkid  = 1'b1;
          nextState = TWO;
        end
      end
      TWO: begin
        // in_ready is low here, so only the drain of main can happen.
        if (outFire) begin
          loadMainFromSkid = 1'b1;
          nextState        = ONE;
        end
      end
      default: begin
        nextState = EMPTY;
      end
    endcase
  end

  // Control is zeroed in the register whenever main turns into a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      mainReg <= '0;
      skidReg <= '0;
    end else if (flush) begin
      mainReg.ctrl <= '0;
      skidReg.ctrl <= '0;
    end else begin
      if (loadMainFromSkid) begin
        mainReg <= skidReg;
      end else if (loadMainFromIn) begin
        mainReg <= inEntry;
      end else if (clearMain) begin
        mainReg.ctrl <= '0;
      end
      if (loadSkid) begin
        skidReg <= inEntry;
      end
    end
  end

`ifdef EX_MEM_BRANCH_RESOLVE_EN
  function automatic logic resolveTaken(input entry_t e);
    return (e.branchEq & e.zero) | (e.branchGt & e.great);
  endfunction

  logic mainTaken;

  // Skid keeps the raw flags, so the decision is recomputed as it moves into main.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      mainTaken <= 1'b0;
    end else if (loadMainFromSkid) begin
      mainTaken <= resolveTaken(skidReg);
    end else if (loadMainFromIn) begin
      mainTaken <= resolveTaken(inEntry);
    end else if (clearMain) begin
      mainTaken <= 1'b0;
    end
  end

  assign bus.out_taken = mainTaken;
`else
  assign bus.out_taken = 1'b0;
`endif

  assign bus.out_valid     = mainValid;
  assign bus.out_rd        = mainReg.rd;
  assign bus.out_alu       = mainReg.alu;
  assign bus.out_store     = mainReg.store;
  assign bus.out_target    = mainReg.target;
  assign bus.out_ctrl      = mainReg.ctrl;
  assign bus.out_zero      = mainReg.zero;
  assign bus.out_great     = mainReg.great;
  assign bus.out_branch_eq = mainReg.branchEq;
  assign bus.out_branch_gt = mainReg.branchGt;
  assign bus.occupancy     = {1'b0, mainValid} + {1'b0, skidValid};

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Self-checking bench for ex_mem_skid_stage against a two-deep FIFO reference model.
// Honours EX_MEM_BRANCH_RESOLVE_EN when predicting out_taken.
module tb_ex_mem_skid_stage;
  localparam int DATA_W = 64;
  localparam int RD_W   = 5;
  localparam int CTRL_W = 4;
`ifdef EX_MEM_BRANCH_RESOLVE_EN
  localparam bit RESOLVE = 1'b1;
`else
  localparam bit RESOLVE = 1'b0;
`endif

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] store;
    logic [DATA_W-1:0] target;
    logic [CTRL_W-1:0] ctrl;
    logic              zero;
    logic              great;
    logic              beq;
    logic              bgt;
  } entry_t;

  typedef struct packed {
    logic       valid;
    logic       inReady;
    logic [1:0] occ;
    logic       taken;
    entry_t     e;
  } view_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  ex_mem_skid_stage_if #(.DATA_W(DATA_W), .RD_W(RD_W), .CTRL_W(CTRL_W)) bus();

  ex_mem_skid_stage #(.DATA_W(DATA_W), .RD_W(RD_W), .CTRL_W(CTRL_W)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  entry_t model[$];

  // Reference: the stage behaves as an in-order queue of at most two entries.
  function automatic logic takenOf(input entry_t e);
    return RESOLVE & ((e.beq & e.zero) | (e.bgt & e.great));
  endfunction

  function automatic view_t expView();
    view_t v;
    v = '0;
    if (model.size() > 0) begin
      v.valid = 1'b1;
      v.e     = model[0];
      v.taken = takenOf(model[0]);
    end
    v.occ     = 2'(model.size());
    v.inReady = (model.size() < 2);
    return v;
  endfunction

  function automatic view_t obsView();
    view_t v;
    v         = '0;
    v.valid   = bus.out_valid;
    v.inReady = bus.in_ready;
    v.occ     = bus.occupancy;
    v.taken   = bus.out_taken;
    if (bus.out_valid === 1'b1) begin
      v.e = {bus.out_rd, bus.out_alu, bus.out_store, bus.out_target, bus.out_ctrl,
             bus.out_zero, bus.out_great, bus.out_branch_eq, bus.out_branch_gt};
    end
    v.e.ctrl = bus.out_ctrl;
    return v;
  endfunction

  function automatic entry_t randEntry();
    entry_t e;
    e.rd     = RD_W'($urandom);
    e.alu    = {$urandom, $urandom};
    e.store  = {$urandom, $urandom};
    e.target = {$urandom, $urandom};
    e.ctrl   = CTRL_W'($urandom);
    e.zero   = 1'($urandom);
    e.great  = 1'($urandom);
    e.beq    = 1'($urandom);
    e.bgt    = 1'($urandom);
    return e;
  endfunction

  // Drives one cycle of stimulus, advances one edge and updates the reference queue.
  task automatic applyStimulus(input logic v, input entry_t e, input logic ordy,
                               input logic fl, input logic rst, output logic accepted);
    int sz;
    sz                = model.size();
    reset             = rst;
    flush             = fl;
    bus.in_valid      = v;
    bus.in_rd         = e.rd;
    bus.in_alu        = e.alu;
    bus.in_store      = e.store;
    bus.in_target     = e.target;
    bus.in_ctrl       = e.ctrl;
    bus.in_zero       = e.zero;
    bus.in_great      = e.great;
    bus.in_branch_eq  = e.beq;
    bus.in_branch_gt  = e.bgt;
    bus.out_ready     = ordy;
    accepted = v && (sz < 2) && !fl && !rst;
    @(posedge clk);
    #1;
    if (rst || fl) begin
      model.delete();
    end else begin
      if (sz > 0 && ordy) void'(model.pop_front());
      if (accepted) model.push_back(e);
    end
  endtask

  task automatic test_reset();
    logic acc;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
    compared++;
    if ({bus.out_valid, bus.out_rd, bus.out_alu, bus.out_store, bus.out_target, bus.out_ctrl,
         bus.out_zero, bus.out_great, bus.out_branch_eq, bus.out_branch_gt, bus.out_taken,
         bus.occupancy} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got valid=%b ctrl=%h alu=%h occ=%0d, required all zero",
               bus.out_valid, bus.out_ctrl, bus.out_alu, bus.occupancy);
    end
    compared++;
    if (bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_in_ready: got %b required 1", bus.in_ready);
    end
  endtask

  task automatic test_stream();
    logic acc;
    entry_t e;
    view_t o, x;
    for (int i = 0; i < 5; i++) begin
      e     = randEntry();
      e.alu = 64'h10 + 64'(i);
      applyStimulus(1'b1, e, 1'b1, 1'b0, 1'b0, acc);
      o = obsView();
      x = expView();
      compared++;
      if (o !== x) begin
        mismatched++;
        $display("[TB] FAIL stream_%0d: got %h required %h", i, o, x);
      end
      compared++;
      if (bus.out_alu !== 64'h10 + 64'(i) || bus.occupancy !== 2'd1) begin
        mismatched++;
        $display("[TB] FAIL stream_alu_%0d: got alu=%h occ=%0d required alu=%h occ=1",
                 i, bus.out_alu, bus.occupancy, 64'h10 + 64'(i));
      end
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
    o = obsView();
    x = expView();
    compared++;
    if (o !== x) begin
      mismatched++;
      $display("[TB] FAIL stream_drain: got %h required %h", o, x);
    end
  endtask

  task automatic test_stall();
    logic acc;
    entry_t a, b, c;
    view_t o, x;
    a = randEntry();
    b = randEntry();
    c = randEntry();
    applyStimulus(1'b1, a, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, b, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, c, 1'b0, 1'b0, 1'b0, acc);
    o = obsView();
    x = expView();
    compared++;
    if (o !== x || bus.in_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL stall_hold: got %h required %h", o, x);
    end
    acc = 1'b0;
    for (int i = 0; i < 4 && !acc; i++) begin
      applyStimulus(1'b1, c, 1'b1, 1'b0, 1'b0, acc);
      o = obsView();
      x = expView();
      compared++;
      if (o !== x) begin
        mismatched++;
        $display("[TB] FAIL stall_release_%0d: got %h required %h", i, o, x);
      end
    end
    compared++;
    if (!acc) begin
      mismatched++;
      $display("[TB] FAIL stall_accept_c: got not accepted required accepted");
    end
    for (int i = 0; i < 4 && model.size() > 0; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
      o = obsView();
      x = expView();
      compared++;
      if (o !== x) begin
        mismatched++;
        $display("[TB] FAIL stall_drain_%0d: got %h required %h", i, o, x);
      end
    end
  endtask

  task automatic test_flush();
    logic acc;
    view_t o, x;
    applyStimulus(1'b1, randEntry(), 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, randEntry(), 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, randEntry(), 1'b0, 1'b1, 1'b0, acc);
    compared++;
    if (bus.out_valid !== 1'b0 || bus.out_ctrl !== '0 || bus.occupancy !== 2'd0 ||
        bus.in_ready !== 1'b1 || bus.out_taken !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL flush_two: got valid=%b ctrl=%h occ=%0d rdy=%b taken=%b required 0/0/0/1/0",
               bus.out_valid, bus.out_ctrl, bus.occupancy, bus.in_ready, bus.out_taken);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
      o = obsView();
      x = expView();
      compared++;
      if (o !== x) begin
        mismatched++;
        $display("[TB] FAIL flush_after_%0d: got %h required %h", i, o, x);
      end
    end
  endtask

  task automatic test_bubble();
    logic acc;
    entry_t e;
    view_t o, x;
    e      = randEntry();
    e.ctrl = 4'b0110;
    applyStimulus(1'b1, e, 1'b1, 1'b0, 1'b0, acc);
    compared++;
    if (bus.out_ctrl !== 4'b0110 || bus.out_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL bubble_entry: got valid=%b ctrl=%b required 1/0110",
               bus.out_valid, bus.out_ctrl);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
      o = obsView();
      x = expView();
      compared++;
      if (o !== x || bus.out_ctrl !== 4'b0000) begin
        mismatched++;
        $display("[TB] FAIL bubble_%0d: got %h required %h", i, o, x);
      end
    end
  endtask

  task automatic test_branch();
    logic acc;
    entry_t e;
    e       = randEntry();
    e.beq   = 1'b1;
    e.zero  = 1'b1;
    e.bgt   = 1'b0;
    e.great = 1'b0;
    applyStimulus(1'b1, e, 1'b1, 1'b0, 1'b0, acc);
    compared++;
    if (bus.out_taken !== RESOLVE) begin
      mismatched++;
      $display("[TB] FAIL branch_eq_taken: got %b required %b", bus.out_taken, RESOLVE);
    end
    e.beq   = 1'b0;
    e.bgt   = 1'b1;
    e.great = 1'b0;
    applyStimulus(1'b1, e, 1'b1, 1'b0, 1'b0, acc);
    compared++;
    if (bus.out_taken !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL branch_gt_not_taken: got %b required 0", bus.out_taken);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
  endtask

  task automatic test_reset_in_two();
    logic acc;
    entry_t e;
    applyStimulus(1'b1, randEntry(), 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, randEntry(), 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, randEntry(), 1'b0, 1'b0, 1'b1, acc);
    compared++;
    if ({bus.out_valid, bus.out_rd, bus.out_alu, bus.out_store, bus.out_target, bus.out_ctrl,
         bus.out_zero, bus.out_great, bus.out_branch_eq, bus.out_branch_gt, bus.out_taken,
         bus.occupancy} !== '0 || bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_in_two: got valid=%b alu=%h occ=%0d rdy=%b required zeros, rdy=1",
               bus.out_valid, bus.out_alu, bus.occupancy, bus.in_ready);
    end
    e = randEntry();
    applyStimulus(1'b1, e, 1'b1, 1'b0, 1'b0, acc);
    compared++;
    if (bus.out_valid !== 1'b1 || bus.out_alu !== e.alu) begin
      mismatched++;
      $display("[TB] FAIL reset_first_entry: got valid=%b alu=%h required 1/%h",
               bus.out_valid, bus.out_alu, e.alu);
    end
  endtask

  task automatic test_random();
    logic acc;
    view_t o, x;
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), randEntry(), 1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 24) == 0), 1'b0, acc);
      o = obsView();
      x = expView();
      compared++;
      if (o !== x) begin
        mismatched++;
        $display("[TB] FAIL random_%0d: got %h required %h", i, o, x);
      end
    end
  endtask

  initial begin
    reset            = 1'b1;
    flush            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_rd        = '0;
    bus.in_alu       = '0;
    bus.in_store     = '0;
    bus.in_target    = '0;
    bus.in_ctrl      = '0;
    bus.in_zero      = 1'b0;
    bus.in_great     = 1'b0;
    bus.in_branch_eq = 1'b0;
    bus.in_branch_gt = 1'b0;
    bus.out_ready    = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_bubble();
    test_branch();
    test_reset_in_two();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
